// File: rtl/ftdi_pkg.sv
// Shared types and defaults for the FT245 link scheduler: FSM states, direction codes, timing defaults.
package ftdi_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RD_OE     = 3'd1,
      RD_STROBE = 3'd2,
      RD_REC    = 3'd3,
      WR_SETUP  = 3'd4,
      WR_STROBE = 3'd5,
      WR_REC    = 3'd6,
      TURN      = 3'd7
   } ftdi_state_e;

   localparam logic DIR_RX = 1'b0;
   localparam logic DIR_TX = 1'b1;

   localparam int DEF_BURST    = 16;
   localparam int DEF_RD_PULSE = 2;
   localparam int DEF_WR_PULSE = 2;
   localparam int DEF_RECOVER  = 3;

endpackage

// File: rtl/ftdi_sync2.sv
// Two-flop synchronizer for the active-low FTDI status pins; resets to 1 (inactive).
module ftdi_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ftdi_link_scheduler.sv
// Owns the FT245 byte FIFO pins; round-robin RX/TX arbitration with per-direction burst quotas.
// Optional FTDI_LINK_STATS_EN adds rx_count/tx_count byte counters.
module ftdi_link_scheduler
   import ftdi_pkg::*;
#(
   parameter int RX_BURST = DEF_BURST,
   parameter int TX_BURST = DEF_BURST,
   parameter int RD_PULSE = DEF_RD_PULSE,
   parameter int WR_PULSE = DEF_WR_PULSE,
   parameter int RECOVER  = DEF_RECOVER
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       ftdi_rxf_n,
   input  logic       ftdi_txe_n,
   output logic       ftdi_rd_n,
   output logic       ftdi_wr_n,
   output logic       ftdi_oe_n,
   input  logic [7:0] ftdi_d_i,
   output logic [7:0] ftdi_d_o,
   output logic       ftdi_d_t,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       grant_dir,
   output logic       busy
`ifdef FTDI_LINK_STATS_EN
   ,
   output logic [31:0] rx_count,
   output logic [31:0] tx_count
`endif
);

   localparam logic [7:0] RX_LIM = 8'(RX_BURST);
   localparam logic [7:0] TX_LIM = 8'(TX_BURST);

   ftdi_state_e state, state_nx;
   logic [7:0]  tmr, count, count_nx, cnt_eff, lim;
   logic        grant_nx, pick, rxf_s_n, txe_s_n, rx_elig, tx_elig, last, cap;

   ftdi_sync2 u_sync_rxf (.clk(clk), .rst(rst), .d(ftdi_rxf_n), .q(rxf_s_n));
   ftdi_sync2 u_sync_txe (.clk(clk), .rst(rst), .d(ftdi_txe_n), .q(txe_s_n));

   function automatic logic [7:0] dur(ftdi_state_e s);
      case (s)
         RD_STROBE:      return 8'(RD_PULSE - 1);
         WR_STROBE:      return 8'(WR_PULSE - 1);
         RD_REC, WR_REC: return 8'(RECOVER - 1);
         default:        return 8'd0;
      endcase
   endfunction

   assign rx_elig = !rxf_s_n && !rx_valid;
   assign tx_elig = !txe_s_n && tx_valid;
   assign last    = (tmr == 8'd0);
   assign lim     = grant_dir ? TX_LIM : RX_LIM;
   assign cap     = (state == RD_STROBE) && last;

   always_comb begin
      state_nx  = state;
      grant_nx  = grant_dir;
      count_nx  = count;
      cnt_eff   = count;
      pick      = grant_dir;
      ftdi_rd_n = (state != RD_STROBE);
      ftdi_oe_n = !(state inside {RD_OE, RD_STROBE});
      ftdi_wr_n = (state != WR_STROBE);
      ftdi_d_t  = state inside {WR_SETUP, WR_STROBE, WR_REC};
      tx_ready  = (state == WR_SETUP);
      busy      = (state != IDLE);

      // at recovery end the byte just finished counts toward the quota
      if ((state == RD_REC || state == WR_REC) && count != lim) cnt_eff = count + 8'd1;
      if (rx_elig && tx_elig) begin
         if (cnt_eff == 8'd0)  pick = !grant_dir;
         else                  pick = (cnt_eff < lim) ? grant_dir : !grant_dir;
      end else if (rx_elig)    pick = DIR_RX;
      else if (tx_elig)        pick = DIR_TX;

      case (state)
         IDLE: if (rx_elig || tx_elig) begin
            state_nx = pick ? WR_SETUP : RD_OE;
            grant_nx = pick;
            if (pick != grant_dir) count_nx = 8'd0;
         end
         RD_OE:     state_nx = RD_STROBE;
         RD_STROBE: if (last) state_nx = RD_REC;
         WR_SETUP:  state_nx = WR_STROBE;
         WR_STROBE: if (last) state_nx = WR_REC;
         RD_REC, WR_REC: if (last) begin
            count_nx = cnt_eff;
            if (!(rx_elig || tx_elig))  state_nx = IDLE;
            else if (pick == grant_dir) state_nx = pick ? WR_SETUP : RD_OE;
            else begin
               state_nx = TURN;
               grant_nx = pick;
               count_nx = 8'd0;
            end
         end
         TURN: begin
            if (grant_dir ? tx_elig : rx_elig) state_nx = grant_dir ? WR_SETUP : RD_OE;
            else                               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         grant_dir <= DIR_TX;
         count     <= 8'd0;
      end else begin
         state     <= state_nx;
         grant_dir <= grant_nx;
         count     <= count_nx;
      end
   end

   // every state is left before it could be re-entered, so a state change reloads the timer
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    tmr <= 8'd0;
      else if (state_nx != state) tmr <= dur(state_nx);
      else if (!last)             tmr <= tmr - 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data  <= 8'd0;
         rx_valid <= 1'b0;
         ftdi_d_o <= 8'd0;
      end else begin
         if (cap) begin
            rx_data  <= ftdi_d_i;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         if (state_nx == WR_SETUP) ftdi_d_o <= tx_data;
      end
   end

`ifdef FTDI_LINK_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_count <= 32'd0;
         tx_count <= 32'd0;
      end else begin
         if (cap)               rx_count <= rx_count + 32'd1;
         if (state == WR_SETUP) tx_count <= tx_count + 32'd1;
      end
   end
`endif

endmodule
